// File: rtl/aes_pkg.sv
// Shared AES constants plus forward and inverse S-box lookups.
// Tables are packed with entry 0 at the MSB end, so lookup x lives at bit
// offset (255-x)*8, i.e. {~x, 3'b000}.
package aes_pkg;

   localparam int unsigned AES_STATE_W = 128;
   localparam int unsigned AES_BYTE_W  = 8;

   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [2047:0] INV_SBOX_TBL = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   // Forward SubBytes lookup.
   function automatic logic [AES_BYTE_W-1:0] sbox(input logic [AES_BYTE_W-1:0] b);
      return SBOX_TBL[{~b, 3'b000} +: AES_BYTE_W];
   endfunction

   // Inverse SubBytes lookup.
   function automatic logic [AES_BYTE_W-1:0] inv_sbox(input logic [AES_BYTE_W-1:0] b);
      return INV_SBOX_TBL[{~b, 3'b000} +: AES_BYTE_W];
   endfunction

endpackage

// File: rtl/inv_sbox_lut.sv
// Combinational single-byte inverse S-box.
//   in_byte    : byte to substitute
//   out_byte_c : InvSbox(in_byte), combinational
module inv_sbox_lut
   import aes_pkg::*;
(
   input  logic [AES_BYTE_W-1:0] in_byte,
   output logic [AES_BYTE_W-1:0] out_byte_c
);

   assign out_byte_c = inv_sbox(in_byte);

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: substitutes BYTES_PER_CYCLE bytes per clock
// through shared inverse S-boxes, starting from byte 0.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : input handshake, in_data captured on handshake
//   out_valid/out_ready  : output handshake, out_data held until consumed
module inv_sub_bytes_iter
   import aes_pkg::*;
#(
   parameter int unsigned BYTES_PER_CYCLE = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [AES_STATE_W-1:0] in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [AES_STATE_W-1:0] out_data
);

   localparam int unsigned NCYC  = 16 / BYTES_PER_CYCLE;
   localparam int unsigned CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;

   if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
         BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
      $error("inv_sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [AES_STATE_W-1:0] work_q, work_d;
   logic [AES_STATE_W-1:0] out_data_q, out_data_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   out_valid_q, out_valid_d;
   logic                   in_ready_q, in_ready_d;

   logic [AES_BYTE_W-1:0]  lut_in  [BYTES_PER_CYCLE];
   logic [AES_BYTE_W-1:0]  lut_out [BYTES_PER_CYCLE];

   // One S-box per lane; lane k handles byte cnt*BPC+k.
   for (genvar k = 0; k < BYTES_PER_CYCLE; k++) begin : g_lane
      assign lut_in[k] =
         work_q[AES_BYTE_W*(BYTES_PER_CYCLE*32'(cnt_q) + 32'(k)) +: AES_BYTE_W];
      inv_sbox_lut u_lut (
         .in_byte    (lut_in[k]),
         .out_byte_c (lut_out[k])
      );
   end

   // Next-state, datapath and registered handshake outputs.
   always_comb begin
      state_d    = state_q;
      work_d     = work_q;
      cnt_d      = cnt_q;
      out_data_d = out_data_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               work_d  = in_data;
               cnt_d   = '0;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            for (int unsigned k = 0; k < BYTES_PER_CYCLE; k++) begin
               work_d[AES_BYTE_W*(BYTES_PER_CYCLE*32'(cnt_q) + k) +: AES_BYTE_W] = lut_out[k];
            end
            if (cnt_q == CNT_W'(NCYC - 1)) begin
               // Result is snapshotted so out_data stays put after it is consumed.
               out_data_d = work_d;
               state_d    = S_DONE;
            end else begin
               cnt_d = CNT_W'(cnt_q + 1'b1);
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Handshake flags follow the next state so they are pure flop outputs.
      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         work_q      <= '0;
         out_data_q  <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         work_q      <= work_d;
         out_data_q  <= out_data_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Self-checking bench for inv_sub_bytes_iter: vector table, round trip
// against a locally computed forward S-box, backpressure, reset and
// back-to-back handshakes, all scored through an expected-result queue.
module tb_inv_sub_bytes_iter;

   localparam int unsigned BPC  = 4;
   localparam int unsigned NCYC = 16 / BPC;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;

   inv_sub_bytes_iter #(.BYTES_PER_CYCLE(BPC)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;
   always @(posedge clk) cyc++;

   logic [127:0] exp_q[$];
   int           lat_q[$];
   logic [7:0]   fwd_tbl [256];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      n_total++;
      $display("FAIL %s: event did not occur as required", name);
   endtask

   // Independent forward S-box: GF(2^8) inverse followed by the affine map.
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = xt(a);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      return 8'((x << n) | (x >> (8 - n)));
   endfunction

   function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
      logic [7:0] r = 8'h01;
      if (a == 8'h00) r = 8'h00;
      else for (int i = 0; i < 254; i++) r = gmul(r, a);
      return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
   endfunction

   // Output monitor, sampled just after the falling edge.
   bit prev_ov = 1'b0;
   always @(negedge clk) begin
      #1;
      if (rst) begin
         prev_ov = 1'b0;
      end else begin
         if (out_valid && !prev_ov) begin
            if (lat_q.size() == 0) fail_now("unexpected_out_valid");
            else chk("latency", 128'(cyc - lat_q.pop_front()), 128'(NCYC));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) fail_now("unexpected_output");
            else chk("out_data", out_data, exp_q.pop_front());
         end
         prev_ov = out_valid;
      end
   end

   // Call at a falling edge; returns at the falling edge after the handshake.
   task automatic send(input logic [127:0] d, input logic [127:0] e,
                       input bit keep_valid, output int hs);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      hs = -1;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         fail_now("in_ready_timeout");
         in_valid = 1'b0;
      end else begin
         hs = cyc + 1;
         exp_q.push_back(e);
         lat_q.push_back(hs);
         @(negedge clk);
         if (!keep_valid) in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() > 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 128'(exp_q.size()), 128'd0);
   endtask

   typedef struct {
      logic [127:0] din;
      logic [127:0] dexp;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int hs, hs1, hs2;
      bit seen;
      logic [127:0] orig, enc, bp_exp;

      vecs[0] = '{128'h63636363_63636363_63636363_63636363, 128'h0};
      vecs[1] = '{128'h637C777B_F26B6FC5_3001672B_FED7AB76, 128'h00010203_04050607_08090A0B_0C0D0E0F};
      vecs[2] = '{128'h0, {16{8'h52}}};
      vecs[3] = '{{16{8'hED}}, {16{8'h53}}};
      vecs[4] = '{{8{16'h00ED}}, {8{16'h5253}}};
      vecs[5] = '{{8{16'hED00}}, {8{16'h5352}}};
      vecs[6] = '{{16{8'h16}}, {16{8'hFF}}};
      vecs[7] = '{{16{8'h7C}}, {16{8'h01}}};

      for (int i = 0; i < 256; i++) fwd_tbl[i] = fwd_sbox(8'(i));

      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b1;
      #3;
      chk("reset_out_valid", 128'(out_valid), 128'd0);
      chk("reset_out_data", out_data, 128'h0);
      chk("reset_in_ready", 128'(in_ready), 128'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Table-driven vectors.
      for (int i = 0; i < 8; i++) send(vecs[i].din, vecs[i].dexp, 1'b0, hs);
      drain();

      // Backpressure: result held, new input refused.
      out_ready = 1'b0;
      bp_exp = {8{16'h5253}};
      send({8{16'h00ED}}, bp_exp, 1'b0, hs);
      begin
         int n = 0;
         while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
         end
      end
      if (!out_valid) fail_now("bp_out_valid_timeout");
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_data  = {16{8'h63}};
         @(negedge clk);
         chk("bp_out_valid", 128'(out_valid), 128'd1);
         chk("bp_out_data", out_data, bp_exp);
         chk("bp_in_ready", 128'(in_ready), 128'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_in_ready", 128'(in_ready), 128'd1);
      chk("bp_release_out_valid", 128'(out_valid), 128'd0);
      chk("bp_release_out_data", out_data, bp_exp);
      drain();

      // Reset during the second BUSY cycle.
      send(vecs[1].din, vecs[1].dexp, 1'b0, hs);
      @(posedge clk);
      #2;
      rst = 1'b1;
      exp_q.delete();
      lat_q.delete();
      #1;
      chk("midrst_out_valid", 128'(out_valid), 128'd0);
      chk("midrst_out_data", out_data, 128'h0);
      chk("midrst_in_ready", 128'(in_ready), 128'd0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      seen = 1'b0;
      repeat (NCYC + 4) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("midrst_no_result", 128'(seen), 128'd0);
      send(vecs[6].din, vecs[6].dexp, 1'b0, hs);
      drain();

      // Back-to-back with in_valid held high.
      send(vecs[1].din, vecs[1].dexp, 1'b1, hs1);
      send(vecs[3].din, vecs[3].dexp, 1'b0, hs2);
      chk("b2b_spacing", 128'(hs2 - hs1), 128'(NCYC + 2));
      drain();

      // Round trip through the forward S-box.
      for (int t = 0; t < 1000; t++) begin
         orig = {$urandom, $urandom, $urandom, $urandom};
         for (int b = 0; b < 16; b++) enc[b*8 +: 8] = fwd_tbl[orig[b*8 +: 8]];
         send(enc, orig, 1'b0, hs);
      end
      drain();

      repeat (NCYC + 4) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/inv_sub_bytes_iter.md
Name: inv_sub_bytes_iter

Overview:
Iterative AES InvSubBytes engine for the decryption datapath. It is the inverse of the forward combinational SubBytes stage. It accepts a 128-bit state over a valid/ready handshake and substitutes BYTES_PER_CYCLE bytes per clock through a shared inverse S-box. The result is held on a valid/ready output until it is consumed, so the inverse S-box area is traded against latency. It sits between inverse ShiftRows and AddRoundKey in the iterative decryption round.

Parameters:
BYTES_PER_CYCLE, 4, bytes substituted per clock; legal values 1, 2, 4, 8, 16 (elaboration error otherwise).
NCYC, 16/BYTES_PER_CYCLE, derived localparam; number of BUSY cycles.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a state
in_data  input  128  ciphertext-side state; byte i = in_data[i*8 +: 8]
out_valid  output  1  out_data holds a completed result
out_ready  input  1  downstream accepts out_data
out_data  output  128  InvSubBytes(in_data); byte i = InvSbox(in byte i)

Behaviour:
- Reset (asynchronous, active-high): state goes to IDLE. out_valid=0, out_data=0, byte counter=0, in_ready=0 while rst is high.
- Reset mid-operation: any in-flight state is discarded. No out_valid is produced for it.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, capture in_data into the working register, clear the counter, and go to BUSY.
  - BUSY: in_ready=0. Each cycle, bytes [cnt*BPC .. cnt*BPC+BPC-1] of the working register are replaced by their InvSbox values; cnt increments. When cnt==NCYC-1 on that edge, go to DONE.
  - DONE: out_valid=1 and out_data=working register (registered, stable). On out_ready, go to IDLE. out_data keeps its value; out_valid drops next cycle.
- Latency: handshake at edge T gives out_valid high after edge T+NCYC (T+4 at default). The minimum input-to-input spacing is NCYC+2 cycles.
- in_valid asserted in BUSY or DONE is ignored, because in_ready=0. The upstream must hold its data.
- out_ready is ignored outside DONE.
- out_valid held with out_ready low: data and valid remain stable indefinitely. This is backpressure.
- in_ready is a pure function of the state register, with no combinational path from out_ready. in_data is sampled only on the handshake edge.
- Byte order: processing starts at byte 0 (LSB) and proceeds upward. The counter width is clog2(NCYC), minimum 1.
- InvSbox is the FIPS-197 inverse table and is total over all 256 inputs. Examples: 63->00, 7C->01, 16->FF, 00->52, ED->53.

Decomposition:
- Shared package aes_pkg holds AES_STATE_W=128, AES_BYTE_W=8 and the inverse S-box function inv_sbox(byte). The forward sbox function moves there alongside it.
- Sub-module inv_sbox_lut: an 8-bit-in, 8-bit-out combinational lookup wrapping the package function. It is instantiated BYTES_PER_CYCLE times in a generate loop.

Test Plan:
1. in_data=128'h63636363_63636363_63636363_63636363 -> out_data=128'h0, with out_valid rising exactly 4 cycles after the handshake (BPC=4).
2. in_data=128'h637C777BF26B6FC53001672BFED7AB76 -> out_data=128'h000102030405060708090A0B0C0D0E0F. Repeat with BPC=1 (latency 16) and BPC=16 (latency 1).
3. Round trip: 1000 random states through the forward SubBytes then this block -> out_data equals the original state. Also check 0x00->0x52 and 0xED->0x53 in every byte lane.
4. Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out_data is stable, in_ready=0, and a new in_valid is not accepted. Release out_ready -> IDLE the next cycle with in_ready=1.
5. Assert rst for one cycle during the 2nd BUSY cycle -> out_valid=0 and out_data=0 immediately (asynchronously). A following state then completes correctly with nominal latency.
6. Back-to-back: in_valid held high with two states and out_ready=1 -> two results in order, with handshakes exactly NCYC+2 cycles apart and no input dropped or duplicated.
